registers_tx_block: RTL and testbench

REGISTERS_TX_BLOCK -- requirements
Module: registers_tx_block

---
 rtl/registers_tx_block_pkg.sv | 15 +
 rtl/registers_tx_block_cmd_fifo.sv | 55 +++++
 rtl/registers_tx_block.sv | 123 ++++++++++++
 tb/tb_registers_tx_block.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/registers_tx_block_pkg.sv
// Shared widths and helpers for the register-frame transmitter.
package registers_tx_block_pkg;

    // Default widths: one address byte followed by a two-byte register value.
    localparam int unsigned TxWidthDefault      = 8;
    localparam int unsigned RegAddrWidthDefault = 8;
    localparam int unsigned RegDataWidthDefault = 16;
    localparam int unsigned FrameCntWidth       = 16;

    // Pointer width for a power-of-two FIFO, never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/registers_tx_block_cmd_fifo.sv
// Command FIFO: stores {addr, data} entries; dout shows the head entry combinationally.
module cmd_fifo
    import registers_tx_block_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (PtrW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Storage array; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/registers_tx_block.sv
// Serialises queued register writes into 3-byte frames: addr, data high, data low.
module registers_tx_block
    import registers_tx_block_pkg::*;
#(
    parameter int unsigned TX_DATA_WIDTH  = TxWidthDefault,
    parameter int unsigned REG_ADDR_WIDTH = RegAddrWidthDefault,
    parameter int unsigned REG_DATA_WIDTH = RegDataWidthDefault,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [REG_DATA_WIDTH-1:0] cmd_data,
    input  logic                      cmd_rdy,
    output logic                      cmd_ack,
    output logic [TX_DATA_WIDTH-1:0]  tx_data,
    output logic                      tx_rdy,
    input  logic                      tx_ack,
    output logic                      busy,
    output logic [FrameCntWidth-1:0]  frames_sent
);

    localparam int unsigned EntryW = REG_ADDR_WIDTH + REG_DATA_WIDTH;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSendAddr = 2'd1,
        StSendDh   = 2'd2,
        StSendDl   = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [EntryW-1:0]        frame_q;
    logic [EntryW-1:0]        fifo_dout;
    logic                     fifo_full, fifo_empty, fifo_pop;
    logic                     start_q, start_d;
    logic                     frame_done;
    logic [FrameCntWidth-1:0] frames_sent_q, frames_sent_d;

    // Reset gating keeps the handshake quiet while the block is held in reset.
    assign cmd_ack = cmd_rdy && !fifo_full && !rst;

    cmd_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_ack),
        .pop   (fifo_pop),
        .din   ({cmd_addr, cmd_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // IDLE waits one cycle after seeing data before popping, giving a fixed
    // two-cycle accept-to-first-byte latency from idle.
    assign start_d = (state_q == StIdle) && !fifo_empty;

    // Next-state logic and pop/frame-complete strobes.
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_q && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StSendAddr;
                end
            end
            StSendAddr: if (tx_ack) state_d = StSendDh;
            StSendDh:   if (tx_ack) state_d = StSendDl;
            StSendDl: begin
                if (tx_ack) begin
                    frame_done = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = StSendAddr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign frames_sent_d = frames_sent_q + FrameCntWidth'(frame_done);

    // State, frame latch and counters; the latch loads only on pop so the
    // in-flight frame is untouched by concurrent pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            start_q       <= 1'b0;
            frame_q       <= '0;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            frames_sent_q <= frames_sent_d;
            if (fifo_pop) frame_q <= fifo_dout;
        end
    end

    // Byte select from the latched frame.
    always_comb begin
        tx_data = '0;
        case (state_q)
            StSendAddr: tx_data = frame_q[EntryW-1 -: TX_DATA_WIDTH];
            StSendDh:   tx_data = frame_q[REG_DATA_WIDTH-1 -: TX_DATA_WIDTH];
            StSendDl:   tx_data = frame_q[TX_DATA_WIDTH-1:0];
            default:    tx_data = '0;
        endcase
    end

    assign tx_rdy      = (state_q != StIdle);
    assign busy        = !fifo_empty || (state_q != StIdle);
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_registers_tx_block.sv
// Scoreboard bench: directed commands push expected bytes; a monitor checks every handshake.
module tb_registers_tx_block;

    logic        clk;
    logic        rst;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_rdy;
    logic        cmd_ack;
    logic [7:0]  tx_data;
    logic        tx_rdy;
    logic        tx_ack;
    logic        busy;
    logic [15:0] frames_sent;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    registers_tx_block #(
        .TX_DATA_WIDTH  (8),
        .REG_ADDR_WIDTH (8),
        .REG_DATA_WIDTH (16),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_rdy     (cmd_rdy),
        .cmd_ack     (cmd_ack),
        .tx_data     (tx_data),
        .tx_rdy      (tx_rdy),
        .tx_ack      (tx_ack),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back(a);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic drive_cmd(input logic [7:0] a, input logic [15:0] d);
        cmd_addr = a;
        cmd_data = d;
        cmd_rdy  = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    // Monitor: compare every accepted byte and the hold-while-stalled rule.
    initial begin
        logic       prev_rdy = 1'b0;
        logic       prev_ack = 1'b0;
        logic [7:0] prev_data = '0;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rdy = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (tx_rdy && prev_rdy && !prev_ack) begin
                    tests++;
                    if (tx_data !== prev_data) begin
                        fails++;
                        $display("FAIL hold: tx_data %0h, required %0h", tx_data, prev_data);
                    end
                end
                if (tx_rdy && tx_ack) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL byte: got %0h, required none", tx_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if (tx_data !== exp) begin
                            fails++;
                            $display("FAIL byte: got %0h, required %0h", tx_data, exp);
                        end
                    end
                end
                prev_rdy  = tx_rdy;
                prev_ack  = tx_ack;
                prev_data = tx_data;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        cmd_rdy  = 1'b1;
        cmd_addr = 8'h00;
        cmd_data = 16'h0000;
        tx_ack   = 1'b0;
        #1;
        check("rst cmd_ack", {31'd0, cmd_ack}, 32'd0);
        check("rst tx_rdy", {31'd0, tx_rdy}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst tx_data", {24'd0, tx_data}, 32'h00);
        check("rst frames", {16'd0, frames_sent}, 32'd0);
        cmd_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single frame, tx_ack always high, two-cycle latency.
        tx_ack = 1'b1;
        drive_cmd(8'h05, 16'h1234);
        expect_frame(8'h05, 16'h1234);
        #1;
        check("single cmd_ack", {31'd0, cmd_ack}, 32'd1);
        tick();
        cmd_rdy = 1'b0;
        check("lat N tx_rdy", {31'd0, tx_rdy}, 32'd0);
        tick();
        check("lat N+1 tx_rdy", {31'd0, tx_rdy}, 32'd0);
        tick();
        check("lat N+2 tx_rdy", {31'd0, tx_rdy}, 32'd1);
        check("lat N+2 tx_data", {24'd0, tx_data}, 32'h05);
        tick();
        tick();
        tick();
        check("single done tx_rdy", {31'd0, tx_rdy}, 32'd0);
        check("single frames", {16'd0, frames_sent}, 32'd1);

        // Backpressure: ack every third cycle.
        tx_ack = 1'b0;
        drive_cmd(8'hA0, 16'hBEEF);
        expect_frame(8'hA0, 16'hBEEF);
        tick();
        cmd_rdy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tx_ack = (c % 3 == 2);
            tick();
        end
        tx_ack = 1'b0;
        wait_idle("bp idle");
        check("bp frames", {16'd0, frames_sent}, 32'd2);

        // FIFO full: one frame stalled in flight, then six offered, four taken.
        drive_cmd(8'h11, 16'h2233);
        expect_frame(8'h11, 16'h2233);
        tick();
        cmd_rdy = 1'b0;
        tick();
        tick();
        check("full stalled tx_rdy", {31'd0, tx_rdy}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            drive_cmd(8'h40 + 8'(i), {8'h50 + 8'(i), 8'h60 + 8'(i)});
            #1;
            check("full cmd_ack", {31'd0, cmd_ack}, (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) expect_frame(8'h40 + 8'(i), {8'h50 + 8'(i), 8'h60 + 8'(i)});
            tick();
        end
        cmd_rdy = 1'b0;
        // Release: 15 bytes back-to-back with no tx_rdy gap.
        tx_ack = 1'b1;
        for (int k = 0; k < 15; k++) begin
            check("b2b tx_rdy", {31'd0, tx_rdy}, 32'd1);
            tick();
        end
        check("b2b end tx_rdy", {31'd0, tx_rdy}, 32'd0);
        check("b2b frames", {16'd0, frames_sent}, 32'd7);

        // Reset mid-frame after the address byte is acked.
        tx_ack = 1'b0;
        drive_cmd(8'h77, 16'h8899);
        exp_q.push_back(8'h77);
        tick();
        drive_cmd(8'h66, 16'h5544);
        tick();
        cmd_rdy = 1'b0;
        for (int n = 0; n < 10 && !tx_rdy; n++) tick();
        check("mid tx_rdy", {31'd0, tx_rdy}, 32'd1);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        rst = 1'b1;
        #1;
        check("mid rst tx_rdy", {31'd0, tx_rdy}, 32'd0);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst tx_data", {24'd0, tx_data}, 32'h00);
        check("mid rst frames", {16'd0, frames_sent}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("no resume tx_rdy", {31'd0, tx_rdy}, 32'd0);
        tx_ack = 1'b1;
        drive_cmd(8'h5A, 16'hC3D2);
        expect_frame(8'h5A, 16'hC3D2);
        tick();
        cmd_rdy = 1'b0;
        wait_idle("restart idle");
        check("restart frames", {16'd0, frames_sent}, 32'd1);

        // Counter wrap from 0xFFFF.
        tx_ack = 1'b0;
        force dut.frames_sent_q = 16'hFFFF;
        tick();
        release dut.frames_sent_q;
        #1;
        check("wrap preload", {16'd0, frames_sent}, 32'hFFFF);
        tx_ack = 1'b1;
        drive_cmd(8'h01, 16'h0203);
        expect_frame(8'h01, 16'h0203);
        tick();
        cmd_rdy = 1'b0;
        wait_idle("wrap idle");
        check("wrap frames", {16'd0, frames_sent}, 32'd0);

        tx_ack = 1'b0;
        tick();
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
